// File: rtl/cmd_issuer.sv
// Host-side initiator for the cmd/rsp FIFO pair: one outstanding command, with a response timeout.
// Optional statistics counters are enabled with `define CMD_ISSUER_STATS_EN.
module cmd_issuer #(
    parameter int unsigned Timeout = 1024,
    parameter logic [31:0] TmoWord = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_cmd_valid_i,
    output logic        host_cmd_ready_o,
    input  logic [31:0] host_cmd_data_i,
    output logic        host_rsp_valid_o,
    input  logic        host_rsp_ready_i,
    output logic [31:0] host_rsp_data_o,
    output logic        host_rsp_err_o,
    output logic [31:0] cmd_wdata_o,
    output logic        cmd_wrreq_o,
    input  logic        cmd_waitreq_i,
    input  logic [31:0] rsp_rdata_i,
    output logic        rsp_rdreq_o,
    input  logic        rsp_waitreq_i
`ifdef CMD_ISSUER_STATS_EN
    ,
    output logic [15:0] stat_cmd_cnt_o,
    output logic [15:0] stat_tmo_cnt_o,
    output logic [15:0] stat_drop_cnt_o
`endif
);

    localparam int unsigned TmrW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
    localparam logic [TmrW-1:0] TmrLast = (Timeout > 0) ? TmrW'(Timeout - 1) : '0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrCmd   = 2'd1,
        StWaitRsp = 2'd2,
        StHold    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TmrW-1:0] timer_q, timer_d, timer_inc;
    logic [31:0]     cmd_q, cmd_d;
    logic [31:0]     rsp_q, rsp_d;
    logic            err_q, err_d;
    logic            tmo_hit;

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign tmo_hit   = (Timeout != 0) && (timer_q == TmrLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            cmd_q   <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cmd_q   <= cmd_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
        end
    end

    // Acceptance of a write or a response takes priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cmd_d   = cmd_q;
        rsp_d   = rsp_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (rsp_waitreq_i && host_cmd_valid_i) begin
                    cmd_d   = host_cmd_data_i;
                    timer_d = '0;
                    state_d = StWrCmd;
                end
            end
            StWrCmd: begin
                if (!cmd_waitreq_i) begin
                    timer_d = '0;
                    state_d = StWaitRsp;
                end else if (tmo_hit) begin
                    rsp_d   = TmoWord;
                    err_d   = 1'b1;
                    state_d = StHold;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StWaitRsp: begin
                if (!rsp_waitreq_i) begin
                    rsp_d   = rsp_rdata_i;
                    err_d   = 1'b0;
                    state_d = StHold;
                end else if (tmo_hit) begin
                    rsp_d   = TmoWord;
                    err_d   = 1'b1;
                    state_d = StHold;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StHold: begin
                if (host_rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Input-dependent strobes are gated by rst_n so every output is low while reset is held.
    always_comb begin
        host_cmd_ready_o = 1'b0;
        host_rsp_valid_o = 1'b0;
        host_rsp_data_o  = '0;
        host_rsp_err_o   = 1'b0;
        cmd_wdata_o      = cmd_q;
        cmd_wrreq_o      = 1'b0;
        rsp_rdreq_o      = 1'b0;
        case (state_q)
            StIdle: begin
                host_cmd_ready_o = rst_n && rsp_waitreq_i;
                rsp_rdreq_o      = rst_n && !rsp_waitreq_i;
            end
            StWrCmd: begin
                cmd_wrreq_o = !cmd_waitreq_i;
            end
            StWaitRsp: begin
                rsp_rdreq_o = !rsp_waitreq_i;
            end
            StHold: begin
                host_rsp_valid_o = 1'b1;
                host_rsp_data_o  = rsp_q;
                host_rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

`ifdef CMD_ISSUER_STATS_EN
    logic [15:0] stat_cmd_q, stat_tmo_q, stat_drop_q;
    logic        cmd_evt, tmo_evt, drop_evt;

    assign cmd_evt  = (state_q == StWrCmd) && !cmd_waitreq_i;
    assign tmo_evt  = tmo_hit && (((state_q == StWrCmd) && cmd_waitreq_i) ||
                                  ((state_q == StWaitRsp) && rsp_waitreq_i));
    assign drop_evt = (state_q == StIdle) && !rsp_waitreq_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cmd_q  <= '0;
            stat_tmo_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            if (cmd_evt && stat_cmd_q != 16'hFFFF) stat_cmd_q <= stat_cmd_q + 16'd1;
            if (tmo_evt && stat_tmo_q != 16'hFFFF) stat_tmo_q <= stat_tmo_q + 16'd1;
            if (drop_evt && stat_drop_q != 16'hFFFF) stat_drop_q <= stat_drop_q + 16'd1;
        end
    end

    assign stat_cmd_cnt_o  = stat_cmd_q;
    assign stat_tmo_cnt_o  = stat_tmo_q;
    assign stat_drop_cnt_o = stat_drop_q;
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: directed corner cases plus random transactions,
// predicted from per-phase cycle counts of stall and response delay.
module tb_cmd_issuer;

    localparam int unsigned TO  = 8;
    localparam logic [31:0] TMO = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_cmd_valid = 1'b0;
    logic        host_cmd_ready;
    logic [31:0] host_cmd_data = '0;
    logic        host_rsp_valid;
    logic        host_rsp_ready = 1'b0;
    logic [31:0] host_rsp_data;
    logic        host_rsp_err;
    logic [31:0] cmd_wdata;
    logic        cmd_wrreq;
    logic        cmd_waitreq = 1'b1;
    logic [31:0] rsp_rdata = '0;
    logic        rsp_rdreq;
    logic        rsp_waitreq = 1'b1;
`ifdef CMD_ISSUER_STATS_EN
    logic [15:0] stat_cmd_cnt, stat_tmo_cnt, stat_drop_cnt;
`endif

    int checks = 0;
    int passes = 0;
    int exp_cmd = 0, exp_tmo = 0, exp_drop = 0;
    logic tmo_flag;

    cmd_issuer #(.Timeout(TO), .TmoWord(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host_cmd_valid_i (host_cmd_valid),
        .host_cmd_ready_o (host_cmd_ready),
        .host_cmd_data_i  (host_cmd_data),
        .host_rsp_valid_o (host_rsp_valid),
        .host_rsp_ready_i (host_rsp_ready),
        .host_rsp_data_o  (host_rsp_data),
        .host_rsp_err_o   (host_rsp_err),
        .cmd_wdata_o      (cmd_wdata),
        .cmd_wrreq_o      (cmd_wrreq),
        .cmd_waitreq_i    (cmd_waitreq),
        .rsp_rdata_i      (rsp_rdata),
        .rsp_rdreq_o      (rsp_rdreq),
        .rsp_waitreq_i    (rsp_waitreq)
`ifdef CMD_ISSUER_STATS_EN
        ,
        .stat_cmd_cnt_o   (stat_cmd_cnt),
        .stat_tmo_cnt_o   (stat_tmo_cnt),
        .stat_drop_cnt_o  (stat_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, host_cmd_ready, 0);
        chk({tag, "_valid"}, host_rsp_valid, 0);
        chk({tag, "_data"}, host_rsp_data, 0);
        chk({tag, "_err"}, host_rsp_err, 0);
        chk({tag, "_wdata"}, cmd_wdata, 0);
        chk({tag, "_wrreq"}, cmd_wrreq, 0);
        chk({tag, "_rdreq"}, rsp_rdreq, 0);
    endtask

    // One full transaction: cmd FIFO stalls `stall` cycles, response shows up after `dly`
    // cycles of waiting, host takes `hold` extra cycles to consume the response.
    task automatic run_txn(input int stall, input int dly, input logic [31:0] cdata,
                           input logic [31:0] rdata, input int hold, output logic tmo);
        logic [31:0] exp_data;
        tmo = 1'b0;
        host_cmd_valid = 1'b1;
        host_cmd_data  = cdata;
        cmd_waitreq    = 1'b1;
        rsp_waitreq    = 1'b1;
        settle();
        chk("idle_ready", host_cmd_ready, 1);
        chk("idle_rdreq", rsp_rdreq, 0);
        chk("idle_wrreq", cmd_wrreq, 0);
        tick();
        host_cmd_valid = 1'b0;
        host_cmd_data  = $urandom;
        for (int i = 0; i < int'(TO); i++) begin
            cmd_waitreq = (i < stall);
            settle();
            chk("wr_wrreq", cmd_wrreq, i >= stall);
            chk("wr_wdata", cmd_wdata, cdata);
            chk("wr_ready", host_cmd_ready, 0);
            chk("wr_valid", host_rsp_valid, 0);
            chk("wr_rdreq", rsp_rdreq, 0);
            if (i >= stall) begin
                exp_cmd++;
                tick();
                break;
            end
            if (i == int'(TO) - 1) begin
                tmo = 1'b1;
                tick();
                break;
            end
            tick();
        end
        cmd_waitreq = 1'b0;
        if (!tmo) begin
            for (int j = 0; j < int'(TO); j++) begin
                rsp_waitreq = (j < dly);
                rsp_rdata   = (j < dly) ? $urandom : rdata;
                settle();
                chk("wt_rdreq", rsp_rdreq, j >= dly);
                chk("wt_wrreq", cmd_wrreq, 0);
                chk("wt_ready", host_cmd_ready, 0);
                chk("wt_valid", host_rsp_valid, 0);
                if (j >= dly) begin
                    tick();
                    break;
                end
                if (j == int'(TO) - 1) begin
                    tmo = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
        end
        rsp_waitreq = 1'b1;
        rsp_rdata   = $urandom;
        cmd_waitreq = 1'($urandom_range(0, 1));
        if (tmo) exp_tmo++;
        exp_data = tmo ? TMO : rdata;
        for (int k = 0; k <= hold; k++) begin
            host_rsp_ready = (k == hold);
            settle();
            chk("hold_valid", host_rsp_valid, 1);
            chk("hold_data", host_rsp_data, exp_data);
            chk("hold_err", host_rsp_err, tmo);
            chk("hold_ready", host_cmd_ready, 0);
            chk("hold_wrreq", cmd_wrreq, 0);
            chk("hold_rdreq", rsp_rdreq, 0);
            tick();
        end
        host_rsp_ready = 1'b0;
        cmd_waitreq    = 1'b1;
    endtask

    // Stale words offered in idle are popped one per cycle while the host is held off.
    task automatic drain(input int n);
        host_cmd_valid = 1'b1;
        host_cmd_data  = $urandom;
        for (int i = 0; i < n; i++) begin
            rsp_waitreq = 1'b0;
            rsp_rdata   = $urandom;
            settle();
            chk("drain_rdreq", rsp_rdreq, 1);
            chk("drain_ready", host_cmd_ready, 0);
            chk("drain_wrreq", cmd_wrreq, 0);
            exp_drop++;
            tick();
        end
        rsp_waitreq    = 1'b1;
        host_cmd_valid = 1'b0;
        settle();
        chk("post_drain_ready", host_cmd_ready, 1);
        chk("post_drain_rdreq", rsp_rdreq, 0);
    endtask

    task automatic chk_stats();
`ifdef CMD_ISSUER_STATS_EN
        chk("stat_cmd", 32'(stat_cmd_cnt), exp_cmd);
        chk("stat_tmo", 32'(stat_tmo_cnt), exp_tmo);
        chk("stat_drop", 32'(stat_drop_cnt), exp_drop);
`endif
    endtask

    initial begin
        // Reset state, with inputs that would raise strobes if not held in reset.
        rsp_waitreq    = 1'b0;
        host_cmd_valid = 1'b1;
        #2;
        chk_all_zero("rst");
        rsp_waitreq = 1'b1;
        #1;
        chk("rst_ready_hi", host_cmd_ready, 0);
        host_cmd_valid = 1'b0;
        chk_stats();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_txn(0, 0, 32'h0100_0005, 32'h8100_0005, 0, tmo_flag);
        run_txn(5, 0, 32'h0200_0001, 32'h8200_0001, 1, tmo_flag);
        run_txn(0, 20, 32'h0300_0002, 32'h1234_5678, 0, tmo_flag);
        chk("tmo_expected", tmo_flag, 1);
        drain(2);
        run_txn(0, int'(TO) - 1, 32'h0400_0003, 32'h8400_0003, 0, tmo_flag);
        run_txn(int'(TO) - 1, 0, 32'h0500_0004, 32'h8500_0004, 2, tmo_flag);
        run_txn(int'(TO), 0, 32'h0600_0005, 32'h8600_0005, 0, tmo_flag);
        chk_stats();

        for (int n = 0; n < 30; n++) begin
            run_txn($urandom_range(0, 9), $urandom_range(0, 9), $urandom, $urandom,
                    $urandom_range(0, 3), tmo_flag);
            if (tmo_flag && $urandom_range(0, 1) == 1) drain($urandom_range(1, 3));
        end
        chk_stats();

        // Reset asserted in the middle of waiting for a response.
        host_cmd_valid = 1'b1;
        host_cmd_data  = 32'h0700_0007;
        settle();
        tick();
        host_cmd_valid = 1'b0;
        cmd_waitreq    = 1'b0;
        settle();
        chk("rstt_wrreq", cmd_wrreq, 1);
        tick();
        cmd_waitreq = 1'b1;
        tick();
        tick();
        rst_n          = 1'b0;
        rsp_waitreq    = 1'b0;
        host_cmd_valid = 1'b1;
        settle();
        chk_all_zero("rst_mid");
        rsp_waitreq = 1'b1;
        settle();
        chk("rst_mid_ready_hi", host_cmd_ready, 0);
        host_cmd_valid = 1'b0;
        exp_cmd  = 0;
        exp_tmo  = 0;
        exp_drop = 0;
        chk_stats();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_txn(1, 2, 32'h0800_0008, 32'h8800_0008, 0, tmo_flag);
        chk("rst_after_tmo", tmo_flag, 0);
        chk_stats();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cmd_issuer.md
Name: cmd_issuer

Overview:
Host-side initiator for the command/response FIFO pair. Takes one 32-bit command per transaction from a host valid/ready port and pushes it into the cmd FIFO. Pops the matching 32-bit response from the rsp FIFO and returns it to the host. Strictly one outstanding command. A timeout covers the case where the far-end engine drops the response because the rsp FIFO was full.

Parameters:
TIMEOUT, 1024, cycles allowed in S_WR_CMD + S_WAIT_RSP before a timeout response is returned; 0 disables the timeout.
TMO_WORD, 32'hDEAD_BEEF, response word returned to the host on timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
host_cmd_valid  in  1  host offers a command
host_cmd_ready  out  1  issuer accepts a command this cycle
host_cmd_data  in  32  command word
host_rsp_valid  out  1  response available to host
host_rsp_ready  in  1  host consumes the response
host_rsp_data  out  32  response word
host_rsp_err  out  1  qualifies host_rsp_data; 1 = timeout word
cmd_wdata  out  32  cmd FIFO write data
cmd_wrreq  out  1  cmd FIFO write strobe
cmd_waitreq  in  1  cmd FIFO full; a write is accepted only when low
rsp_rdata  in  32  rsp FIFO show-ahead data, valid while rsp_waitreq is low
rsp_rdreq  out  1  rsp FIFO pop strobe
rsp_waitreq  in  1  rsp FIFO empty; goes low when data is present

Behaviour:
- Reset (async, any state): fsm=S_IDLE; timer=0; cmd_q=0; rsp_q=0; err_q=0. All strobes and valids are 0.
- FSM has 4 states: S_IDLE=0, S_WR_CMD=1, S_WAIT_RSP=2, S_HOLD=3. Unreachable encodings go to S_IDLE.
- S_IDLE, stale drain:
  - If rsp_waitreq=0, assert rsp_rdreq=1 and host_cmd_ready=0, and discard the word.
  - This drains responses that arrive after a timeout. One word is popped per cycle.
- S_IDLE, accept:
  - Otherwise host_cmd_ready=1.
  - On host_cmd_valid: cmd_q<=host_cmd_data, timer<=0, go to S_WR_CMD.
- S_WR_CMD:
  - cmd_wdata=cmd_q at all times.
  - cmd_wrreq = !cmd_waitreq, combinational.
  - If cmd_waitreq=0, the write is accepted: timer<=0, go to S_WAIT_RSP.
  - Else timer++.
- S_WAIT_RSP:
  - If rsp_waitreq=0: rsp_rdreq=1 in the same cycle, rsp_q<=rsp_rdata, err_q<=0, go to S_HOLD.
  - Else timer++.
- Timeout, applies in S_WR_CMD and S_WAIT_RSP when TIMEOUT!=0:
  - Triggers when timer==TIMEOUT-1 and no acceptance happens this cycle.
  - rsp_q<=TMO_WORD, err_q<=1, go to S_HOLD.
  - On a timeout in S_WR_CMD, cmd_wrreq is still driven that cycle only if cmd_waitreq=0. By definition that is not a timeout, so the command is never written.
- Simultaneous events: data arriving or a write being accepted in the timeout cycle wins; the real response is returned, not a timeout.
- Timer is sized clog2(TIMEOUT+1) and saturates; it never wraps.
- S_HOLD:
  - host_rsp_valid=1, host_rsp_data=rsp_q, host_rsp_err=err_q.
  - Outputs are stable until the handshake.
  - On host_rsp_ready, go to S_IDLE. The earliest next command is accepted in the following cycle.
- Latency, both FIFOs ready:
  - Command accepted at cycle T.
  - cmd_wrreq at T+1.
  - Response popped at T+2 at the earliest.
  - host_rsp_valid from T+3.
- host_cmd_ready=0 and rsp_rdreq=0 in S_WR_CMD, S_WAIT_RSP and S_HOLD (drain only happens in S_IDLE).

Optional Feature:
Macro CMD_ISSUER_STATS_EN.
- When defined, adds these outputs:
  - stat_cmd_cnt[15:0]: commands written to the cmd FIFO.
  - stat_tmo_cnt[15:0]: timeouts.
  - stat_drop_cnt[15:0]: stale words drained in S_IDLE.
- All counters reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Both FIFOs ready; host sends 32'h0100_0005; rsp FIFO returns 32'h8100_0005 → cmd_wrreq at T+1 with cmd_wdata=32'h0100_0005; host_rsp_valid at T+3 with data 32'h8100_0005, err=0.
- cmd_waitreq held high 5 cycles → cmd_wrreq stays 0 throughout; exactly one write occurs on the 6th cycle; host_cmd_ready=0 throughout.
- TIMEOUT=8, rsp_waitreq always high → host_rsp_valid with 32'hDEAD_BEEF, err=1, 8 cycles after the write is accepted.
- TIMEOUT=8, response appears in exactly the timeout cycle → real data returned, err=0.
- After a timeout, 2 stale words arrive in S_IDLE → 2 rsp_rdreq pulses, host_cmd_ready=0 meanwhile; stat_drop_cnt=2 with CMD_ISSUER_STATS_EN.
- Assert rst_n low in S_WAIT_RSP → all outputs 0 immediately; after release, a new command completes normally.
